// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings, default register indices and index type
package cpu_pkg;

   localparam int NUM_REGS_DEFAULT = 32;
   localparam int LINK_REG_DEFAULT = 31;
   localparam int FLAG_REG_DEFAULT = 30;

   typedef enum logic [1:0] {
      WB_SRC_ALU  = 2'd0,
      WB_SRC_MEM  = 2'd1,
      WB_SRC_LINK = 2'd2,
      WB_SRC_RSVD = 2'd3
   } wb_src_e;

   typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wb_sb_if.sv
// rtl/regfile_wb_sb_if.sv - decode/write-back bus into the register file
interface regfile_wb_sb_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 32,
   parameter int READ_PORTS = 2,
   parameter int OVF_CNT_W  = 8
);
   localparam int AW = $clog2(NUM_REGS);

   logic [READ_PORTS*AW-1:0]     rd_addr;
   logic [READ_PORTS*DATA_W-1:0] rd_data;
   logic [READ_PORTS-1:0]        rd_busy;
   logic                         iss_valid;
   logic [AW-1:0]                iss_addr;
   logic                         wb_en;
   logic [AW-1:0]                wb_addr;
   logic [1:0]                   wb_src;
   logic [DATA_W-1:0]            alu_res;
   logic                         alu_ovf;
   logic [DATA_W-1:0]            mem_data;
   logic                         addr_err;
   logic                         link_en;
   logic [DATA_W-1:0]            link_data;
   logic                         ovf_flag;
   logic [OVF_CNT_W-1:0]         ovf_count;

   modport master (
      output rd_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_src, alu_res, alu_ovf,
             mem_data, addr_err, link_en, link_data,
      input  rd_data, rd_busy, ovf_flag, ovf_count
   );

   modport slave (
      input  rd_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_src, alu_res, alu_ovf,
             mem_data, addr_err, link_en, link_data,
      output rd_data, rd_busy, ovf_flag, ovf_count
   );

endinterface

// File: rtl/regfile_wb_sb_scoreboard.sv
// rtl/regfile_wb_sb_scoreboard.sv - per-register busy bits for in-flight writes
module reg_scoreboard #(
   parameter int NUM_REGS   = 32,
   parameter int READ_PORTS = 2,
   parameter int LINK_REG   = 31,
   parameter int BYPASS     = 1,
   localparam int AW        = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iss_valid,
   input  logic [AW-1:0]            iss_addr,
   input  logic                     wb_en,
   input  logic [AW-1:0]            wb_addr,
   input  logic                     link_en,
   input  logic [READ_PORTS*AW-1:0] rd_addr,
   output logic [READ_PORTS-1:0]    rd_busy
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [AW-1:0]       rd_idx;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid) set_vec[iss_addr] = 1'b1;
      if (wb_en)     clr_vec[wb_addr]  = 1'b1;
      if (link_en)   clr_vec[LINK_REG] = 1'b1;
      set_vec[0] = 1'b0;
   end

   // A new issue is a younger writer than the one completing, so set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= (busy & ~clr_vec) | set_vec;
   end

   always_comb begin
      rd_busy = '0;
      rd_idx  = '0;
      for (int k = 0; k < READ_PORTS; k++) begin
         rd_idx     = rd_addr[k*AW +: AW];
         rd_busy[k] = busy[rd_idx] &&
                      !((BYPASS != 0) && clr_vec[rd_idx] && !set_vec[rd_idx]);
      end
   end

endmodule

// File: rtl/regfile_wb_sb.sv
// rtl/regfile_wb_sb.sv - multi-port register file with write-back exception
// suppression, overflow flag/counter, write bypass and busy scoreboard
module regfile_wb_sb
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = NUM_REGS_DEFAULT,
   parameter int READ_PORTS = 2,
   parameter int LINK_REG   = LINK_REG_DEFAULT,
   parameter int FLAG_REG   = FLAG_REG_DEFAULT,
   parameter int BYPASS     = 1,
   parameter int OVF_CNT_W  = 8
) (
   input logic          clk,
   input logic          reset,
   regfile_wb_sb_if.slave bus
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
   localparam logic [AW-1:0] FLAG_IDX = AW'(FLAG_REG);

   logic [DATA_W-1:0]            regs [NUM_REGS];
   logic [DATA_W-1:0]            wb_data;
   logic                         commit;
   logic                         wb_write;
   logic                         link_write;
   logic                         flag_set;
   logic                         flag_clr;
   logic                         ovf_pending;
   logic [OVF_CNT_W-1:0]         ovf_count_q;
   logic [AW-1:0]                rd_idx;
   logic [DATA_W-1:0]            rd_val;
   logic [READ_PORTS*DATA_W-1:0] rd_data_c;

   always_comb begin
      case (wb_src_e'(bus.wb_src))
         WB_SRC_MEM:  wb_data = bus.mem_data;
         WB_SRC_LINK: wb_data = bus.link_data;
         default:     wb_data = bus.alu_res;
      endcase
   end

   assign commit     = bus.wb_en && !bus.alu_ovf && !bus.addr_err;
   assign wb_write   = commit && (bus.wb_addr != '0);
   assign link_write = bus.link_en && (LINK_IDX != '0) &&
                       !(wb_write && (bus.wb_addr == LINK_IDX));
   assign flag_set   = bus.wb_en && bus.alu_ovf;
   // An explicit write to the flag register overrides the pending clear.
   assign flag_clr   = commit && ovf_pending && !(wb_write && (bus.wb_addr == FLAG_IDX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         ovf_pending <= 1'b0;
         ovf_count_q <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_write && (bus.wb_addr == AW'(i)))
               regs[i] <= wb_data;
            else if (link_write && (LINK_IDX == AW'(i)))
               regs[i] <= bus.link_data;
            else if ((FLAG_IDX == AW'(i)) && flag_set)
               regs[i] <= DATA_W'(1);
            else if ((FLAG_IDX == AW'(i)) && flag_clr)
               regs[i] <= '0;
         end
         if (flag_set)    ovf_pending <= 1'b1;
         else if (commit) ovf_pending <= 1'b0;
         if (flag_set && (ovf_count_q != '1))
            ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_idx    = '0;
      rd_val    = '0;
      for (int k = 0; k < READ_PORTS; k++) begin
         rd_idx = bus.rd_addr[k*AW +: AW];
         rd_val = regs[rd_idx];
         if (BYPASS != 0) begin
            if (wb_write && (bus.wb_addr == rd_idx))
               rd_val = wb_data;
            else if (link_write && (LINK_IDX == rd_idx))
               rd_val = bus.link_data;
         end
         if (rd_idx == '0) rd_val = '0;
         rd_data_c[k*DATA_W +: DATA_W] = rd_val;
      end
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.ovf_flag  = regs[FLAG_REG][0];
   assign bus.ovf_count = ovf_count_q;

   reg_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .READ_PORTS (READ_PORTS),
      .LINK_REG   (LINK_REG),
      .BYPASS     (BYPASS)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (bus.iss_valid),
      .iss_addr  (bus.iss_addr),
      .wb_en     (bus.wb_en),
      .wb_addr   (bus.wb_addr),
      .link_en   (bus.link_en),
      .rd_addr   (bus.rd_addr),
      .rd_busy   (bus.rd_busy)
   );

endmodule

// File: tb/tb_regfile_wb_sb.sv
// tb/tb_regfile_wb_sb.sv - scoreboard bench for regfile_wb_sb with directed vectors
module tb_regfile_wb_sb;
   import cpu_pkg::*;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int RP = 2;
   localparam int AW = 5;
   localparam int CW = 8;

   localparam int K_DATA  = 0;
   localparam int K_BUSY  = 1;
   localparam int K_FLAG  = 2;
   localparam int K_COUNT = 3;

   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [31:0] mon_act;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_wb_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .READ_PORTS(RP), .OVF_CNT_W(CW)) bus ();

   regfile_wb_sb #(.DATA_W(DW), .NUM_REGS(NR), .READ_PORTS(RP), .LINK_REG(31),
                   .FLAG_REG(30), .BYPASS(1), .OVF_CNT_W(CW))
      dut (.clk(clk), .reset(reset), .bus(bus));

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         case (mon_e.kind)
            K_DATA:  mon_act = bus.rd_data[mon_e.port*DW +: DW];
            K_BUSY:  mon_act = 32'(bus.rd_busy[mon_e.port]);
            K_FLAG:  mon_act = 32'(bus.ovf_flag);
            default: mon_act = 32'(bus.ovf_count);
         endcase
         checks++;
         if (mon_act !== mon_e.val) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_e.name, mon_act, mon_e.val);
         end
      end
   end

   task automatic push(input string name, input int kind, input int port, input logic [31:0] val);
      exp_t e;
      e.name = name; e.kind = kind; e.port = port; e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic clr_in();
      bus.iss_valid = 1'b0; bus.iss_addr = '0;
      bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_src = 2'd0;
      bus.alu_res = '0; bus.alu_ovf = 1'b0; bus.mem_data = '0; bus.addr_err = 1'b0;
      bus.link_en = 1'b0; bus.link_data = '0;
   endtask

   task automatic rd(input int p, input int a);
      bus.rd_addr[p*AW +: AW] = AW'(a);
   endtask

   // The unselected data source carries the complement so a wrong mux pick shows.
   task automatic set_wb(input int addr, input logic [1:0] src, input logic [31:0] val,
                         input logic ovf, input logic err);
      bus.wb_en    = 1'b1;
      bus.wb_addr  = AW'(addr);
      bus.wb_src   = src;
      bus.alu_res  = (src == WB_SRC_MEM) ? ~val : val;
      bus.mem_data = (src == WB_SRC_MEM) ? val : ~val;
      bus.alu_ovf  = ovf;
      bus.addr_err = err;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clr_in();
      bus.rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      rd(0, 31); rd(1, 0);
      push("rst_r31", K_DATA, 0, 32'h0);
      push("rst_r0", K_DATA, 1, 32'h0);
      push("rst_busy", K_BUSY, 0, 32'h0);
      push("rst_count", K_COUNT, 0, 32'h0);
      push("rst_flag", K_FLAG, 0, 32'h0);
      step();
      reset = 1'b0;

      // Preload every register, mark 20 busy, then reset mid-write.
      for (int i = 1; i < NR; i++) begin
         set_wb(i, WB_SRC_ALU, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
         step();
      end
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(20);
      step();
      rd(0, 5); rd(1, 31);
      push("pre_r5", K_DATA, 0, 32'hA000_0005);
      push("pre_r31", K_DATA, 1, 32'hA000_001F);
      step();
      rd(0, 20);
      push("pre_busy20", K_BUSY, 0, 32'h1);
      step();
      set_wb(7, WB_SRC_ALU, 32'h77, 1'b0, 1'b0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1 clr_in();
      rd(0, 31); rd(1, 20);
      push("arst_r31", K_DATA, 0, 32'h0);
      push("arst_r20", K_DATA, 1, 32'h0);
      push("arst_busy20", K_BUSY, 1, 32'h0);
      step();
      reset = 1'b0;
      rd(0, 7); rd(1, 1);
      push("arst_r7_dropped", K_DATA, 0, 32'h0);
      push("arst_r1", K_DATA, 1, 32'h0);
      step();

      // ALU write with same-cycle bypass
      set_wb(5, WB_SRC_ALU, 32'h1234, 1'b0, 1'b0);
      rd(0, 5);
      push("byp_r5", K_DATA, 0, 32'h1234);
      step();
      push("r5_next", K_DATA, 0, 32'h1234);
      step();

      // Overflow suppression, then a clean commit clears the flag
      set_wb(8, WB_SRC_ALU, 32'h88, 1'b0, 1'b0);
      step();
      set_wb(8, WB_SRC_ALU, 32'hDEAD, 1'b1, 1'b0);
      rd(0, 8);
      push("ovf_no_fwd", K_DATA, 0, 32'h88);
      step();
      rd(0, 8); rd(1, 30);
      push("ovf_r8", K_DATA, 0, 32'h88);
      push("ovf_r30", K_DATA, 1, 32'h1);
      push("ovf_flag", K_FLAG, 0, 32'h1);
      push("ovf_count1", K_COUNT, 0, 32'h1);
      step();
      set_wb(9, WB_SRC_ALU, 32'h7, 1'b0, 1'b0);
      step();
      rd(0, 9); rd(1, 30);
      push("clr_r9", K_DATA, 0, 32'h7);
      push("clr_r30", K_DATA, 1, 32'h0);
      push("clr_flag", K_FLAG, 0, 32'h0);
      step();

      // Address error squashes the write, clears busy, leaves the flag alone
      set_wb(10, WB_SRC_ALU, 32'h10, 1'b0, 1'b0);
      step();
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(10);
      step();
      set_wb(11, WB_SRC_ALU, 32'h5, 1'b1, 1'b0);
      step();
      set_wb(10, WB_SRC_MEM, 32'hBAD, 1'b0, 1'b1);
      rd(0, 10);
      push("aerr_no_fwd", K_DATA, 0, 32'h10);
      push("aerr_busy_byp", K_BUSY, 0, 32'h0);
      step();
      rd(0, 10); rd(1, 30);
      push("aerr_r10", K_DATA, 0, 32'h10);
      push("aerr_busy10", K_BUSY, 0, 32'h0);
      push("aerr_r30", K_DATA, 1, 32'h1);
      push("aerr_flag", K_FLAG, 0, 32'h1);
      push("aerr_count2", K_COUNT, 0, 32'h2);
      step();

      // Register 0 ignores write and issue; the commit still clears the flag
      set_wb(0, WB_SRC_ALU, 32'hFFFF_FFFF, 1'b0, 1'b0);
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(0);
      rd(0, 0);
      push("r0_byp", K_DATA, 0, 32'h0);
      push("r0_busy_byp", K_BUSY, 0, 32'h0);
      step();
      push("r0_data", K_DATA, 0, 32'h0);
      push("r0_busy", K_BUSY, 0, 32'h0);
      push("r0_flag_clr", K_FLAG, 0, 32'h0);
      step();

      // Link versus write-back priority, link source, reserved source
      set_wb(31, WB_SRC_ALU, 32'h99, 1'b0, 1'b0);
      bus.link_en = 1'b1; bus.link_data = 32'h40;
      rd(1, 31);
      push("wb_link_byp", K_DATA, 1, 32'h99);
      step();
      push("wb_link_r31", K_DATA, 1, 32'h99);
      step();
      bus.link_en = 1'b1; bus.link_data = 32'h40;
      push("link_byp", K_DATA, 1, 32'h40);
      step();
      push("link_r31", K_DATA, 1, 32'h40);
      step();
      set_wb(3, WB_SRC_LINK, 32'h0, 1'b0, 1'b0);
      bus.link_en = 1'b1; bus.link_data = 32'h44;
      step();
      set_wb(4, WB_SRC_RSVD, 32'h4444, 1'b0, 1'b0);
      step();
      rd(0, 3); rd(1, 31);
      push("src_link_r3", K_DATA, 0, 32'h44);
      push("src_link_r31", K_DATA, 1, 32'h44);
      step();
      rd(0, 4);
      push("src_rsvd_r4", K_DATA, 0, 32'h4444);
      step();

      // Data write to the flag register wins over the pending clear
      set_wb(13, WB_SRC_ALU, 32'h1, 1'b1, 1'b0);
      step();
      set_wb(30, WB_SRC_ALU, 32'h7, 1'b0, 1'b0);
      step();
      rd(1, 30);
      push("flagreg_r30", K_DATA, 1, 32'h7);
      push("flagreg_flag", K_FLAG, 0, 32'h1);
      push("count3", K_COUNT, 0, 32'h3);
      step();

      // Busy scoreboard: set, set-beats-clear, clear bypass, link clear
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(12);
      step();
      rd(1, 12);
      push("busy12_set", K_BUSY, 1, 32'h1);
      step();
      set_wb(12, WB_SRC_ALU, 32'h12, 1'b0, 1'b0);
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(12);
      step();
      push("busy12_set_wins", K_BUSY, 1, 32'h1);
      push("r12_first", K_DATA, 1, 32'h12);
      step();
      set_wb(12, WB_SRC_ALU, 32'h13, 1'b0, 1'b0);
      push("busy12_clr_byp", K_BUSY, 1, 32'h0);
      push("r12_byp", K_DATA, 1, 32'h13);
      step();
      push("busy12_clr", K_BUSY, 1, 32'h0);
      step();
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(31);
      step();
      rd(0, 31);
      push("busy31_set", K_BUSY, 0, 32'h1);
      step();
      bus.link_en = 1'b1; bus.link_data = 32'h50;
      push("busy31_link_byp", K_BUSY, 0, 32'h0);
      step();
      push("busy31_link_clr", K_BUSY, 0, 32'h0);
      push("r31_link50", K_DATA, 0, 32'h50);
      step();

      // Overflow counter saturation
      for (int i = 0; i < 256; i++) begin
         set_wb(14, WB_SRC_ALU, 32'h1, 1'b1, 1'b0);
         step();
      end
      rd(0, 14);
      push("sat_count", K_COUNT, 0, 32'hFF);
      push("sat_flag", K_FLAG, 0, 32'h1);
      push("sat_r14", K_DATA, 0, 32'h0);
      step();

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
